// File: rtl/clk_sel_ctrl.sv
// Programmable clock divider (N = 2/4/8/16/28/5) with glitch-free divide change at period boundary.
// Outputs registered, one cycle behind cnt; sel_req held until sel_ack. Optional period counter: CLK_SEL_PERIOD_CNT_EN.
module clk_sel_ctrl (
  input  logic        clkIn,
  input  logic        rst,
  input  logic        run,
  input  logic        sel_req,
  input  logic [2:0]  sel_div,
  output logic        sel_ack,
  output logic        sel_err,
  output logic        busy,
  output logic [2:0]  cur_div,
  output logic        clk_en,
  output logic        div_out,
  output logic [15:0] period_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] cnt;
  logic [4:0] last_cnt;
  logic [4:0] half_cnt;
  logic [2:0] pend_div;
  logic       armed;
  logic       err_q;
  logic       code_ok;
  logic       accept;

  function automatic logic [4:0] div_last(input logic [2:0] code);
    logic [4:0] r;
    case (code)
      3'd0:    r = 5'd1;
      3'd1:    r = 5'd3;
      3'd2:    r = 5'd7;
      3'd3:    r = 5'd15;
      3'd4:    r = 5'd27;
      3'd5:    r = 5'd4;
      default: r = 5'd1;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] div_half(input logic [2:0] code);
    logic [4:0] r;
    case (code)
      3'd0:    r = 5'd1;
      3'd1:    r = 5'd2;
      3'd2:    r = 5'd4;
      3'd3:    r = 5'd8;
      3'd4:    r = 5'd14;
      3'd5:    r = 5'd2;
      default: r = 5'd1;
    endcase
    return r;
  endfunction

  assign last_cnt = div_last(cur_div);
  assign half_cnt = div_half(cur_div);
  assign code_ok  = (sel_div <= 3'd5);
  // A request counts only once sel_req has been seen low since the last accepted one.
  assign accept   = (state == RUN) && sel_req && armed;

  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    sel_ack   = err_q;
    case (state)
      RUN: begin
        if (accept && code_ok) begin
          state_nxt = PEND;
        end
      end
      PEND: begin
        busy = 1'b1;
        if (!run || (cnt == last_cnt)) begin
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        sel_ack   = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign sel_err = err_q;

  // The APPLY cycle is a dead cycle (div_out low, no clk_en) so the new
  // divisor always starts from cnt=0 with a full-length first period.
  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      cnt     <= 5'd0;
      clk_en  <= 1'b0;
      div_out <= 1'b0;
    end else begin
      if (state == APPLY) begin
        cnt <= 5'd0;
      end else if (run) begin
        cnt <= (cnt == last_cnt) ? 5'd0 : cnt + 5'd1;
      end
      clk_en  <= run && (state != APPLY) && (cnt == last_cnt);
      div_out <= run && (state != APPLY) && (cnt < half_cnt);
    end
  end

  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      cur_div  <= 3'd0;
      pend_div <= 3'd0;
      err_q    <= 1'b0;
      armed    <= 1'b1;
    end else begin
      if (state == APPLY) begin
        cur_div <= pend_div;
      end
      if (accept && code_ok) begin
        pend_div <= sel_div;
      end
      err_q <= accept && !code_ok;
      if (accept) begin
        armed <= 1'b0;
      end else if (!sel_req) begin
        armed <= 1'b1;
      end
    end
  end

`ifdef CLK_SEL_PERIOD_CNT_EN
  logic [15:0] period_q;

  // Counts visible clk_en pulses; APPLY clear wins over a coincident pulse.
  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      period_q <= 16'd0;
    end else if (state == APPLY) begin
      period_q <= 16'd0;
    end else if (clk_en) begin
      period_q <= period_q + 16'd1;
    end
  end

  assign period_cnt = period_q;
`else
  assign period_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed bench for clk_sel_ctrl; expectations hand-traced per cycle (edge k = k-th clkIn rise after reset release).
module tb_clk_sel_ctrl;

  logic        clkIn = 1'b0;
  logic        rst;
  logic        run;
  logic        sel_req;
  logic [2:0]  sel_div;
  logic        sel_ack;
  logic        sel_err;
  logic        busy;
  logic [2:0]  cur_div;
  logic        clk_en;
  logic        div_out;
  logic [15:0] period_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int lo;
  logic ack_seen;

`ifdef CLK_SEL_PERIOD_CNT_EN
  localparam bit PCNT_EN = 1'b1;
`else
  localparam bit PCNT_EN = 1'b0;
`endif

  clk_sel_ctrl dut (
    .clkIn      (clkIn),
    .rst        (rst),
    .run        (run),
    .sel_req    (sel_req),
    .sel_div    (sel_div),
    .sel_ack    (sel_ack),
    .sel_err    (sel_err),
    .busy       (busy),
    .cur_div    (cur_div),
    .clk_en     (clk_en),
    .div_out    (div_out),
    .period_cnt (period_cnt)
  );

  always #5 clkIn = ~clkIn;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  // Waits (bounded) for sel_ack, returning cycles taken and div_out-low samples seen.
  task automatic wait_ack(input int max_cyc, output int n_cyc, output int n_lo);
    n_cyc = 0;
    n_lo  = 0;
    do begin
      tick();
      n_cyc++;
      if (!div_out) n_lo++;
    end while (!sel_ack && n_cyc < max_cyc);
    chk("ack_seen", 32'(sel_ack), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    run     = 1'b0;
    sel_req = 1'b0;
    sel_div = 3'd0;
    tick();
    tick();
    chk("rst_ack",    32'(sel_ack),    32'd0);
    chk("rst_err",    32'(sel_err),    32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_cur",    32'(cur_div),    32'd0);
    chk("rst_clk_en", 32'(clk_en),     32'd0);
    chk("rst_div",    32'(div_out),    32'd0);
    chk("rst_pcnt",   32'(period_cnt), 32'd0);

    // N=2 free-running after release
    rst = 1'b1;
    run = 1'b1;
    chk("rel_div_hold", 32'(div_out), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("n2_div[%0d]", k), 32'(div_out), 32'(k % 2));
      chk($sformatf("n2_en[%0d]", k),  32'(clk_en),  32'((k % 2) == 0));
    end

    // switch to N=5; sel_div change during PEND must be ignored
    sel_req = 1'b1;
    sel_div = 3'd5;
    tick();
    chk("n5_busy",     32'(busy),    32'd1);
    chk("n5_ack_pend", 32'(sel_ack), 32'd0);
    sel_div = 3'd2;
    tick();
    chk("n5_ack",      32'(sel_ack), 32'd1);
    chk("n5_busy_off", 32'(busy),    32'd0);
    chk("n5_err",      32'(sel_err), 32'd0);
    chk("n5_cur_old",  32'(cur_div), 32'd0);
    sel_req = 1'b0;
    sel_div = 3'd0;
    tick();
    chk("n5_cur",      32'(cur_div), 32'd5);
    chk("n5_ack_gone", 32'(sel_ack), 32'd0);
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk($sformatf("n5_div[%0d]", j), 32'(div_out), 32'(((j - 1) % 5) < 2));
      chk($sformatf("n5_en[%0d]", j),  32'(clk_en),  32'((j % 5) == 0));
    end

    // invalid code; request held past ack must not be re-accepted
    sel_req = 1'b1;
    sel_div = 3'd6;
    tick();
    chk("inv_ack",  32'(sel_ack), 32'd1);
    chk("inv_err",  32'(sel_err), 32'd1);
    chk("inv_busy", 32'(busy),    32'd0);
    chk("inv_cur",  32'(cur_div), 32'd5);
    tick();
    chk("inv_rearm_ack", 32'(sel_ack), 32'd0);
    chk("inv_rearm_err", 32'(sel_err), 32'd0);
    sel_req = 1'b0;
    tick();

    // N=28, then request N=4 at cnt=3
    sel_req = 1'b1;
    sel_div = 3'd4;
    wait_ack(40, cyc, lo);
    chk("n28_lat", 32'(cyc), 32'd2);
    sel_req = 1'b0;
    tick();
    chk("n28_cur", 32'(cur_div), 32'd4);
    tick();
    tick();
    tick();
    sel_req = 1'b1;
    sel_div = 3'd1;
    wait_ack(60, cyc, lo);
    chk("n28_to_n4_lat", 32'(cyc), 32'd25);
    chk("n28_low_phase", 32'(lo),  32'd14);
    sel_req = 1'b0;
    tick();
    chk("n4_cur",  32'(cur_div), 32'd1);
    chk("n4_gap",  32'(div_out), 32'd0);
    chk("n4_ack0", 32'(sel_ack), 32'd0);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk($sformatf("n4_div[%0d]", j), 32'(div_out), 32'(((j - 1) % 4) < 2));
      chk($sformatf("n4_en[%0d]", j),  32'(clk_en),  32'((j % 4) == 0));
    end

    // asynchronous reset while PEND
    sel_req = 1'b1;
    sel_div = 3'd2;
    tick();
    chk("pr_busy", 32'(busy), 32'd1);
    #2;
    rst     = 1'b0;
    sel_req = 1'b0;
    #1;
    chk("pr_busy_async", 32'(busy),       32'd0);
    chk("pr_cur_async",  32'(cur_div),    32'd0);
    chk("pr_div_async",  32'(div_out),    32'd0);
    chk("pr_en_async",   32'(clk_en),     32'd0);
    chk("pr_ack_async",  32'(sel_ack),    32'd0);
    chk("pr_pcnt_async", 32'(period_cnt), 32'd0);
    tick();
    chk("pr_ack_held",  32'(sel_ack), 32'd0);
    rst      = 1'b1;
    ack_seen = 1'b0;
    repeat (4) begin
      tick();
      ack_seen = ack_seen | sel_ack;
    end
    chk("pr_no_ack", 32'(ack_seen), 32'd0);
    chk("pr_cur",    32'(cur_div),  32'd0);
    chk("pr_en4",    32'(clk_en),   32'd1);
    chk("pr_div4",   32'(div_out),  32'd0);

    // period counter, same-code request, pause/resume, PEND with run=0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (21) tick();
    chk("pcnt_10", 32'(period_cnt), PCNT_EN ? 32'd10 : 32'd0);
    sel_req = 1'b1;
    sel_div = 3'd0;
    wait_ack(20, cyc, lo);
    chk("same_lat", 32'(cyc), 32'd3);
    sel_req = 1'b0;
    tick();
    chk("same_cur",   32'(cur_div),    32'd0);
    chk("pcnt_clear", 32'(period_cnt), 32'd0);
    run = 1'b0;
    repeat (3) tick();
    chk("pause_en",  32'(clk_en),  32'd0);
    chk("pause_div", 32'(div_out), 32'd0);
    run = 1'b1;
    tick();
    chk("resume_div", 32'(div_out), 32'd1);
    chk("resume_en",  32'(clk_en),  32'd0);
    tick();
    chk("resume_div2", 32'(div_out), 32'd0);
    chk("resume_en2",  32'(clk_en),  32'd1);
    run     = 1'b0;
    sel_req = 1'b1;
    sel_div = 3'd3;
    wait_ack(20, cyc, lo);
    chk("idle_lat", 32'(cyc), 32'd2);
    sel_req = 1'b0;
    tick();
    chk("idle_cur",  32'(cur_div),    32'd3);
    chk("idle_busy", 32'(busy),       32'd0);
    chk("idle_pcnt", 32'(period_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_sel_ctrl.md
CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

Interface
REQ-001 SHALL have port clkIn, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset: asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port run, input, 1, 1 = divider running, 0 = paused.
REQ-004 SHALL have port sel_req, input, 1, divide-change request; held high by requester until sel_ack.
REQ-005 SHALL have port sel_div, input, 3, requested divide code, valid while sel_req=1.
REQ-006 SHALL have port sel_ack, output, 1, one-cycle pulse closing a request.
REQ-007 SHALL have port sel_err, output, 1, one-cycle pulse with sel_ack when sel_div is invalid.
REQ-008 SHALL have port busy, output, 1, high while a request is accepted but not yet applied.
REQ-009 SHALL have port cur_div, output, 3, divide code currently in effect.
REQ-010 SHALL have port clk_en, output, 1, one-cycle enable pulse once per output period.
REQ-011 SHALL have port div_out, output, 1, divided square wave.
REQ-012 SHALL have port period_cnt, output, 16, count of completed output periods.

Function
REQ-013 Divide codes SHALL map 0->N=2, 1->4, 2->8, 3->16, 4->28, 5->5; codes 6,7 invalid.
REQ-014 A 5-bit phase counter cnt SHALL count 0..N-1 while run=1, wrapping N-1 -> 0.
REQ-015 clk_en SHALL be registered, high exactly in the cycle after cnt==N-1 is reached (one pulse per N cycles).
REQ-016 div_out SHALL be registered, high while cnt < floor(N/2), else low (N=5: 2 high, 3 low).
REQ-017 FSM states: RUN, PEND, APPLY; reset state RUN.
REQ-018 RUN: sel_req=1 with valid code -> capture sel_div into pending register, go PEND, busy=1.
REQ-019 RUN: sel_req=1 with invalid code -> sel_ack=1 and sel_err=1 next cycle, stay RUN, cur_div unchanged.
REQ-020 PEND: remain until cnt==N-1 (current period completes, no truncated period), then APPLY.
REQ-021 PEND with run=0: SHALL go to APPLY next cycle (no period in progress).
REQ-022 APPLY: cur_div <= pending, cnt <= 0, sel_ack=1 for one cycle, busy=0, return RUN.
REQ-023 First period after APPLY SHALL have full new length N; no output glitch shorter than min(old,new) half-period.
REQ-024 Request to same code as cur_div SHALL still follow PEND/APPLY and restart phase at period boundary.
REQ-025 After sel_ack, a new request SHALL be accepted only after sel_req has been seen low for at least one cycle.
REQ-026 sel_req changes and sel_div changes during PEND SHALL be ignored.
REQ-027 run=0: cnt held, clk_en=0, div_out=0; run 0->1 resumes from held cnt.
REQ-028 run deasserting in the same cycle as cnt==N-1 in PEND: APPLY SHALL still occur next cycle.

Reset
REQ-029 rst=0 SHALL immediately force: state RUN, cnt=0, cur_div=0 (N=2), pending=0, sel_ack=0, sel_err=0, busy=0, clk_en=0, div_out=0, period_cnt=0.
REQ-030 Reset during PEND SHALL discard the pending request without sel_ack; requester must re-request.
REQ-031 Outputs SHALL hold reset values until the first rising clkIn edge after rst returns to 1.

Configuration
REQ-032 Macro CLK_SEL_PERIOD_CNT_EN defined: period_cnt increments by 1 with each clk_en pulse, wraps 16'hFFFF -> 0, clears on APPLY.
REQ-033 Macro CLK_SEL_PERIOD_CNT_EN undefined: period_cnt SHALL be constant 0 and no counter logic is synthesized.

Verification
REQ-034 Reset release, run=1, no request -> clk_en every 2 cycles, div_out toggles every cycle, cur_div=0.
REQ-035 Request sel_div=5 mid-period of N=2 -> busy=1, switch at period end, sel_ack 1 cycle, then div_out 2 high/3 low, clk_en every 5 cycles.
REQ-036 Request sel_div=6 -> sel_ack and sel_err same cycle, cur_div unchanged, busy never high.
REQ-037 N=28 running, request sel_div=1 at cnt=3 -> ack exactly 25 cycles later, no truncated high/low phase.
REQ-038 rst=0 pulse during PEND -> all outputs reset asynchronously, no sel_ack, cur_div=0.
REQ-039 With CLK_SEL_PERIOD_CNT_EN, 10 clk_en pulses -> period_cnt=10, cleared to 0 on next APPLY; without macro period_cnt=0 throughout.
